// File: rtl/tfe_flow_tracker.sv
// Multi-channel flow tracker: round-robin intake, direct-mapped flow table, ready FIFO.
// Define TFE_BYTE_CNT_EN to keep a saturating per-flow byte count in each entry.
module tfe_flow_tracker #(
    parameter int NUM_CH     = 2,
    parameter int HASH_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8,
    parameter int SIZE_W     = 16,
    parameter int BYTE_W     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*HASH_W-1:0] i_hash,
    input  logic [NUM_CH*SIZE_W-1:0] i_pkt_size,
    input  logic [NUM_CH-1:0]        i_valid,
    output logic [NUM_CH-1:0]        o_ready,
    input  logic [CNT_W-1:0]         threshold,
    output logic [ADDR_W-1:0]        o_fea_addr,
    output logic                     o_fea_addr_v,
    output logic                     o_fea_empty,
    input  logic                     fetch_addr_en,
    input  logic                     free_one_flow,
    input  logic [ADDR_W-1:0]        free_addr,
    output logic                     o_init_done,
    output logic [15:0]              o_drop_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TAG_W = HASH_W - ADDR_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic              rep;
        logic [TAG_W-1:0]  tag;
        logic [CNT_W-1:0]  cnt;
`ifdef TFE_BYTE_CNT_EN
        logic [BYTE_W-1:0] bytes;
`endif
    } entry_t;

    typedef enum logic [1:0] {INIT, IDLE, READ, UPDATE} state_t;

    entry_t            tbl_q [DEPTH];
    entry_t            rd_q;
    entry_t            wr_ent;
    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_wa;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_q, init_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   gnt;
    logic              gnt_v;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic [15:0]       drop_q, drop_d;

    logic [ADDR_W-1:0] fifo_q [FIFO_DEPTH];
    logic [FP_W-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [FP_W:0]     fcnt_q, fcnt_d;
    logic              push, pop, full;

    logic [ADDR_W-1:0] idx;
    logic [TAG_W-1:0]  tag;
    logic [CNT_W-1:0]  thr;
    logic              hit;

`ifdef TFE_BYTE_CNT_EN
    logic [SIZE_W-1:0] size_q, size_d;
    logic [BYTE_W:0]   bsum;
`else
    logic              unused_size;
    assign unused_size = ^i_pkt_size;
`endif

    assign idx  = hash_q[ADDR_W-1:0];
    assign tag  = hash_q[HASH_W-1:ADDR_W];
    assign thr  = (threshold == '0) ? CNT_W'(1) : threshold;
    assign hit  = !rd_q.valid || (rd_q.tag == tag);
    assign full = (fcnt_q == (FP_W+1)'(FIFO_DEPTH));
    assign pop  = fetch_addr_en && (fcnt_q != '0) && (state_q != INIT);

    always_comb begin : arb
        int              c;
        logic [CH_W-1:0] ci;
        gnt_v = 1'b0;
        gnt   = '0;
        c     = 0;
        ci    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(rr_q) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            ci = CH_W'(c);
            if (!gnt_v && i_valid[ci]) begin
                gnt_v = 1'b1;
                gnt   = ci;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        rr_d    = rr_q;
        hash_d  = hash_q;
        drop_d  = drop_q;
        o_ready = '0;
        tbl_we  = 1'b0;
        tbl_wa  = idx;
        wr_ent  = '0;
        push    = 1'b0;
`ifdef TFE_BYTE_CNT_EN
        size_d  = size_q;
        bsum    = '0;
`endif
        unique case (state_q)
            INIT: begin
                tbl_we = 1'b1;
                tbl_wa = init_q;
                init_d = init_q + ADDR_W'(1);
                if (&init_q) state_d = IDLE;
            end
            IDLE: begin
                if (free_one_flow) begin
                    tbl_we = 1'b1;
                    tbl_wa = free_addr;
                end else if (gnt_v) begin
                    o_ready[gnt] = 1'b1;
                    hash_d = i_hash[gnt*HASH_W +: HASH_W];
`ifdef TFE_BYTE_CNT_EN
                    size_d = i_pkt_size[gnt*SIZE_W +: SIZE_W];
`endif
                    rr_d = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + CH_W'(1);
                    state_d = READ;
                end
            end
            READ: state_d = UPDATE;
            UPDATE: begin
                tbl_we = 1'b1;
                wr_ent = rd_q;
                if (!rd_q.valid) begin
                    wr_ent.valid = 1'b1;
                    wr_ent.rep   = 1'b0;
                    wr_ent.tag   = tag;
                    wr_ent.cnt   = CNT_W'(1);
`ifdef TFE_BYTE_CNT_EN
                    wr_ent.bytes = BYTE_W'(size_q);
`endif
                end else if (hit) begin
                    if (rd_q.cnt != '1) wr_ent.cnt = rd_q.cnt + CNT_W'(1);
`ifdef TFE_BYTE_CNT_EN
                    bsum = {1'b0, rd_q.bytes} + (BYTE_W+1)'(size_q);
                    wr_ent.bytes = bsum[BYTE_W] ? '1 : bsum[BYTE_W-1:0];
`endif
                end else if (drop_q != '1) begin
                    drop_d = drop_q + 16'd1;
                end
                // A full FIFO leaves rep clear so the next packet retries
                if (hit && !wr_ent.rep && wr_ent.cnt >= thr && (!full || pop)) begin
                    push       = 1'b1;
                    wr_ent.rep = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        fcnt_d = fcnt_q;
        if (push) wp_d = wp_q + FP_W'(1);
        if (pop) rp_d = rp_q + FP_W'(1);
        if (push && !pop) fcnt_d = fcnt_q + (FP_W+1)'(1);
        else if (pop && !push) fcnt_d = fcnt_q - (FP_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            init_q  <= '0;
            rr_q    <= '0;
            hash_q  <= '0;
            drop_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
`ifdef TFE_BYTE_CNT_EN
            size_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            rr_q    <= rr_d;
            hash_q  <= hash_d;
            drop_q  <= drop_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fcnt_q  <= fcnt_d;
`ifdef TFE_BYTE_CNT_EN
            size_q  <= size_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[tbl_wa] <= wr_ent;
        if (state_q == READ) rd_q <= tbl_q[idx];
        if (push) fifo_q[wp_q] <= idx;
    end

    assign o_fea_addr_v = (fcnt_q != '0);
    assign o_fea_empty  = ~o_fea_addr_v;
    assign o_fea_addr   = o_fea_addr_v ? fifo_q[rp_q] : '0;
    assign o_init_done  = (state_q != INIT);
    assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_tfe_flow_tracker.sv
// Scoreboard bench for tfe_flow_tracker: flow-table/FIFO reference model plus
// directed phases (init, threshold, drop, arbitration, FIFO full, free, reset).
module tb_tfe_flow_tracker;

    localparam int NUM_CH = 2;
    localparam int HASH_W = 32;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;
    localparam int SIZE_W = 16;
    localparam int FD     = 16;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*HASH_W-1:0] i_hash;
    logic [NUM_CH*SIZE_W-1:0] i_pkt_size;
    logic [NUM_CH-1:0]        i_valid;
    logic [NUM_CH-1:0]        o_ready;
    logic [CNT_W-1:0]         threshold;
    logic [ADDR_W-1:0]        o_fea_addr;
    logic                     o_fea_addr_v;
    logic                     o_fea_empty;
    logic                     fetch_addr_en;
    logic                     free_one_flow;
    logic [ADDR_W-1:0]        free_addr;
    logic                     o_init_done;
    logic [15:0]              o_drop_cnt;

    tfe_flow_tracker #(
        .NUM_CH(NUM_CH), .HASH_W(HASH_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .SIZE_W(SIZE_W), .BYTE_W(24), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .i_hash(i_hash), .i_pkt_size(i_pkt_size),
        .i_valid(i_valid), .o_ready(o_ready), .threshold(threshold),
        .o_fea_addr(o_fea_addr), .o_fea_addr_v(o_fea_addr_v),
        .o_fea_empty(o_fea_empty), .fetch_addr_en(fetch_addr_en),
        .free_one_flow(free_one_flow), .free_addr(free_addr),
        .o_init_done(o_init_done), .o_drop_cnt(o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: flow table by index, expected FIFO contents, RR pointer
    bit          m_valid [1024];
    bit          m_rep   [1024];
    int          m_tag   [1024];
    int          m_cnt   [1024];
    int          m_drop;
    int          m_rr;
    int          exp_q [$];
    bit          pend_v;
    int          pend_age;
    logic [31:0] pend_hash;
    bit          mon_en = 0;
    int          cyc = 0;
    int          last_gnt = -1;
    bit          phase_c = 0;

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 0;
            m_rep[i]   = 0;
            m_tag[i]   = 0;
            m_cnt[i]   = 0;
        end
        exp_q.delete();
        pend_v = 0;
        m_rr   = 0;
        m_drop = 0;
    endfunction

    function automatic void apply_pkt(input logic [31:0] h);
        int ix, tg, th;
        ix = int'(h[9:0]);
        tg = int'(h[31:10]);
        th = (threshold == 0) ? 1 : int'(threshold);
        if (!m_valid[ix]) begin
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
            m_cnt[ix]   = 1;
            m_rep[ix]   = 0;
        end else if (m_tag[ix] == tg) begin
            if (m_cnt[ix] < 255) m_cnt[ix]++;
        end else begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        if (!m_rep[ix] && m_cnt[ix] >= th && exp_q.size() < FD) begin
            exp_q.push_back(ix);
            m_rep[ix] = 1;
        end
    endfunction

    task automatic monitor_step();
        logic [NUM_CH-1:0] er;
        bit idle;
        idle = !pend_v;
        er = '0;
        if (idle && !free_one_flow)
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_rr + i) % NUM_CH;
                if (er == 0 && i_valid[c]) er[c] = 1'b1;
            end
        chk("o_ready", o_ready, er);
        chk("fea_v", o_fea_addr_v, exp_q.size() != 0);
        chk("fea_empty", o_fea_empty, exp_q.size() == 0);
        chk("drop_cnt", o_drop_cnt, m_drop);
        if (exp_q.size() != 0) begin
            chk("fea_addr", o_fea_addr, exp_q[0]);
            if (fetch_addr_en) void'(exp_q.pop_front());
        end
        if (pend_v) begin
            pend_age++;
            if (pend_age == 2) begin
                apply_pkt(pend_hash);
                pend_v = 0;
            end
        end else if (free_one_flow) begin
            m_valid[free_addr] = 0;
            m_rep[free_addr]   = 0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++)
                if (i_valid[ch] && o_ready[ch]) begin
                    pend_v    = 1;
                    pend_age  = 0;
                    pend_hash = i_hash[ch*HASH_W +: HASH_W];
                    m_rr      = (ch + 1) % NUM_CH;
                    if (phase_c && last_gnt >= 0) chk("grant_gap", cyc - last_gnt, 3);
                    last_gnt = cyc;
                end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            model_reset();
            mon_en = 0;
        end else begin
            if (o_init_done) mon_en = 1;
            if (mon_en) monitor_step();
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n;
        bit bad;
        n = 0;
        bad = 0;
        while (!o_init_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (o_ready != 0 || o_fea_empty !== 1'b1) bad = 1;
        end
        chk("init_cycles", n, 1024);
        chk("init_quiet", bad, 0);
    endtask

    task automatic send(input int ch, input logic [31:0] h, input logic [15:0] sz);
        bit got;
        got = 0;
        i_hash[ch*HASH_W +: HASH_W] = h;
        i_pkt_size[ch*SIZE_W +: SIZE_W] = sz;
        i_valid[ch] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (o_ready[ch]) got = 1;
        end
        @(posedge clk);
        #1;
        i_valid[ch] = 1'b0;
        chk("send_grant", got, 1);
    endtask

    task automatic drain(output int n);
        int guard;
        n = 0;
        guard = 0;
        while (o_fea_addr_v && guard < 100) begin
            fetch_addr_en = 1'b1;
            @(posedge clk);
            #1;
            fetch_addr_en = 1'b0;
            n++;
            guard++;
        end
    endtask

    task automatic run_dual(input int ncyc);
        phase_c = 1;
        last_gnt = -1;
        repeat (ncyc) begin
            i_valid = '1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                i_hash[ch*HASH_W +: HASH_W] =
                    {22'($urandom_range(1, 2)), 10'($urandom_range(64, 95))};
                i_pkt_size[ch*SIZE_W +: SIZE_W] = 16'($urandom);
            end
            fetch_addr_en = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            #1;
        end
        i_valid = '0;
        fetch_addr_en = 1'b0;
        phase_c = 0;
        idle_cycles(4);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_hash = '0;
        i_pkt_size = '0;
        i_valid = '0;
        threshold = 8'd3;
        fetch_addr_en = 1'b0;
        free_one_flow = 1'b0;
        free_addr = '0;
        model_reset();

        @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_v", o_fea_addr_v, 0);
        chk("rst_empty", o_fea_empty, 1);
        chk("rst_addr", o_fea_addr, 0);
        chk("rst_done", o_init_done, 0);
        chk("rst_drop", o_drop_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init();

        // threshold reporting, one push only
        threshold = 8'd3;
        for (int k = 0; k < 3; k++) send(0, 32'h0000_1005, 16'd100);
        idle_cycles(4);
        chk("thr_addr", o_fea_addr, 10'h005);
        chk("thr_v", o_fea_addr_v, 1);
        send(0, 32'h0000_1005, 16'd100);
        idle_cycles(4);

        // tag collision drop
        send(0, 32'h0000_2005, 16'd50);
        idle_cycles(4);
        chk("drop_one", o_drop_cnt, 1);
        drain(n);
        chk("drain_thr", n, 1);

        // continuous dual-channel traffic, random fetches
        threshold = 8'd0;
        run_dual(90);
        threshold = 8'd2;
        run_dual(120);
        drain(n);
        idle_cycles(2);
        chk("drained_empty", o_fea_empty, 1);

        // FIFO full, then retry after one pop
        threshold = 8'd1;
        for (int k = 0; k < FD; k++)
            send(k % NUM_CH, {22'h3F, 10'(512 + k)}, 16'd64);
        idle_cycles(4);
        send(0, {22'h3F, 10'h210}, 16'd64);
        idle_cycles(4);
        chk("full_head", o_fea_addr, 10'h200);
        fetch_addr_en = 1'b1;
        @(posedge clk);
        #1;
        fetch_addr_en = 1'b0;
        send(1, {22'h3F, 10'h210}, 16'd64);
        idle_cycles(4);
        drain(n);
        chk("full_drain", n, 16);

        // free has priority over a waiting packet; flow reinstalls
        threshold = 8'd1;
        free_one_flow = 1'b1;
        free_addr = 10'h005;
        i_hash[0 +: HASH_W] = 32'h0000_1005;
        i_valid[0] = 1'b1;
        @(negedge clk);
        chk("free_blocks_ready", o_ready, 0);
        @(posedge clk);
        #1;
        free_one_flow = 1'b0;
        send(0, 32'h0000_1005, 16'd100);
        idle_cycles(4);
        chk("reinstall_v", o_fea_addr_v, 1);
        chk("reinstall_addr", o_fea_addr, 10'h005);
        drain(n);
        chk("reinstall_drain", n, 1);

        // reset while a packet is in flight redoes the sweep
        i_hash[HASH_W +: HASH_W] = 32'h0000_2ABC;
        i_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        i_valid[1] = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        wait_init();
        chk("reset_drop", o_drop_cnt, 0);
        send(0, 32'h0000_1005, 16'd10);
        idle_cycles(4);
        chk("post_reset_v", o_fea_addr_v, 1);
        drain(n);
        chk("post_reset_drain", n, 1);
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

endmodule
